// File: rtl/spi_slave_regbank.sv
// SPI slave register bridge: an external SPI master writes the mosi bank and
// reads the miso bank, while the ARM side reads mosi and writes miso.
// Frame = CS low, command byte {W, INC, .., addr}, then DATA_W-bit words,
// all MSB first, CPHA = 0 with configurable clock polarity.
module spi_slave_regbank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter bit CPOL   = 1'b0
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   SPI_CLK,
  input  logic                   SPI_CS,
  input  logic                   SPI_MOSI,
  output logic                   SPI_MISO,
  input  logic                   Data_WE,
  input  logic [ADDR_W-1:0]      Data_Addr,
  input  logic [DATA_W-1:0]      Data_Write,
  output logic [DATA_W-1:0]      Data_Read,
  input  logic                   Data_RE,
  output logic [2**ADDR_W-1:0]   Data_New,
  output logic                   Frame_Err,
  output logic                   Busy
);

  localparam int NREG  = 2**ADDR_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CMD_BITS  = CNT_W'(8);
  localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  // Synchroniser chains: [0] and [1] are the 2-FF synchroniser, [2] is the
  // delayed copy used for edge detection.
  logic [2:0] sclk_q, sclk_d;
  logic [2:0] cs_q, cs_d;
  logic [1:0] mosi_q, mosi_d;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              miso_q, miso_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic              inc_q, inc_d;
  logic              err_q, err_d;
  logic [NREG-1:0]   new_q, new_d;

  logic [DATA_W-1:0] mosi_bank_q [NREG];
  logic [DATA_W-1:0] miso_bank_q [NREG];

  logic              lead, trail, cs_fall, cs_high, mosi_s;
  logic              mosi_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_word;

  // Synchroniser next values and edge/level decode of the SPI pins.
  always_comb begin
    sclk_d  = {sclk_q[1:0], SPI_CLK};
    cs_d    = {cs_q[1:0], SPI_CS};
    mosi_d  = {mosi_q[0], SPI_MOSI};
    lead    = (sclk_q[1] != sclk_q[2]) && (sclk_q[1] != CPOL);
    trail   = (sclk_q[1] != sclk_q[2]) && (sclk_q[1] == CPOL);
    cs_fall = cs_q[2] & ~cs_q[1];
    cs_high = cs_q[1];
    mosi_s  = mosi_q[1];
  end

  // Address of the next miso word: command address at the end of the
  // command byte, otherwise the (optionally incremented) current address.
  always_comb begin
    load_addr = (state_q == CMD) ? shift_q[ADDR_W-1:0]
                                 : (inc_q ? addr_q + 1'b1 : addr_q);
    load_word = miso_bank_q[load_addr];
  end

  // Frame FSM: one shifter serves both directions; MOSI enters at the LSB on
  // leading edges while the MSB feeds MISO on trailing edges.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    miso_d  = miso_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    inc_d   = inc_q;
    err_d   = 1'b0;
    mosi_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          shift_d = '0;
          miso_d  = 1'b0;
        end
      end
      CMD: begin
        if (lead) begin
          shift_d = {shift_q[DATA_W-2:0], mosi_s};
          cnt_d   = cnt_q + 1'b1;
        end else if (trail && cnt_q == CMD_BITS) begin
          addr_d  = shift_q[ADDR_W-1:0];
          wr_d    = shift_q[7];
          inc_d   = shift_q[6];
          shift_d = load_word;
          miso_d  = load_word[DATA_W-1];
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (lead) begin
          shift_d = {shift_q[DATA_W-2:0], mosi_s};
          cnt_d   = cnt_q + 1'b1;
        end else if (trail) begin
          if (cnt_q == WORD_BITS) begin
            mosi_we = wr_q;
            addr_d  = load_addr;
            shift_d = load_word;
            miso_d  = load_word[DATA_W-1];
            cnt_d   = '0;
          end else begin
            miso_d  = shift_q[DATA_W-1];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // CS release aborts the frame from any active state; a unit cut short
    // is reported and its bits are dropped.
    if (cs_high && state_q != IDLE) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      mosi_we = 1'b0;
      err_d   = (cnt_q != '0) &&
                (((state_q == CMD)  && (cnt_q < CMD_BITS)) ||
                 ((state_q == DATA) && (cnt_q < WORD_BITS)));
    end

    // New flags: ARM acknowledge clears, SPI write sets; set has priority.
    new_d = new_q;
    if (Data_RE) new_d[Data_Addr] = 1'b0;
    if (mosi_we) new_d[addr_q]    = 1'b1;
  end

  // State, shifter and synchroniser registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sclk_q  <= {3{CPOL}};
      cs_q    <= 3'b111;
      mosi_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      miso_q  <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      inc_q   <= 1'b0;
      err_q   <= 1'b0;
      new_q   <= '0;
    end else begin
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      miso_q  <= miso_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      inc_q   <= inc_d;
      err_q   <= err_d;
      new_q   <= new_d;
    end
  end

  // Register banks; the shifter load above reads the pre-write miso value.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        mosi_bank_q[i] <= '0;
        miso_bank_q[i] <= '0;
      end
    end else begin
      if (mosi_we) mosi_bank_q[addr_q]    <= shift_q;
      if (Data_WE) miso_bank_q[Data_Addr] <= Data_Write;
    end
  end

  assign SPI_MISO  = miso_q;
  assign Frame_Err = err_q;
  assign Busy      = (state_q != IDLE);
  assign Data_Read = mosi_bank_q[Data_Addr];
  assign Data_New  = new_q;

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Bench for spi_slave_regbank: two instances (CPOL=0 and CPOL=1) see the
// same bus, with the CPOL=1 clock inverted, and are checked against one
// frame-level model of the register banks.
module tb_spi_slave_regbank;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        sclk, cs, mosi;
  logic        we, re;
  logic [3:0]  addr;
  logic [31:0] wdata;

  logic        miso0, miso1, fe0, fe1, busy0, busy1;
  logic [31:0] rd0, rd1;
  logic [15:0] new0, new1;

  spi_slave_regbank #(.DATA_W(32), .ADDR_W(4), .CPOL(1'b0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .SPI_CLK(sclk), .SPI_CS(cs), .SPI_MOSI(mosi),
    .SPI_MISO(miso0), .Data_WE(we), .Data_Addr(addr), .Data_Write(wdata),
    .Data_Read(rd0), .Data_RE(re), .Data_New(new0), .Frame_Err(fe0), .Busy(busy0)
  );

  spi_slave_regbank #(.DATA_W(32), .ADDR_W(4), .CPOL(1'b1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .SPI_CLK(~sclk), .SPI_CS(cs), .SPI_MOSI(mosi),
    .SPI_MISO(miso1), .Data_WE(we), .Data_Addr(addr), .Data_Write(wdata),
    .Data_Read(rd1), .Data_RE(re), .Data_New(new1), .Frame_Err(fe1), .Busy(busy1)
  );

  always #5 Clk = ~Clk;

  // Behavioural model
  logic [31:0] m_mosi [16];
  logic [31:0] m_miso [16];
  logic [15:0] m_new;
  logic        m_busy;
  int          exp_err_total = 0;

  logic        exp_miso = 1'b0;
  logic        miso_chk = 1'b0;
  logic        rx_bit;
  logic [31:0] tx_words [4];
  logic [31:0] rx_words [4];
  logic [3:0]  coll_addr;
  logic [31:0] coll_data;

  int cyc = 0;
  int last_evt = 0;
  int err_seen0 = 0, err_seen1 = 0;
  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Compare process: MISO before each leading edge, everything else once
  // the DUT has had time to absorb the last bus event.
  always @(negedge Clk) begin
    cyc = cyc + 1;
    if (fe0) err_seen0++;
    if (fe1) err_seen1++;
    if (miso_chk) begin
      check("miso_cpol0", miso0, exp_miso);
      check("miso_cpol1", miso1, exp_miso);
    end
    if (cyc - last_evt >= 6) begin
      check("busy0", busy0, m_busy);
      check("busy1", busy1, m_busy);
      check("new0", new0, m_new);
      check("new1", new1, m_new);
      check("read0", rd0, m_mosi[addr]);
      check("read1", rd1, m_mosi[addr]);
      check("ferr0", err_seen0, exp_err_total);
      check("ferr1", err_seen1, exp_err_total);
      if (!m_busy) begin
        check("idle_miso0", miso0, 1'b0);
        check("idle_miso1", miso1, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_mosi[i] = '0;
      m_miso[i] = '0;
    end
    m_new  = '0;
    m_busy = 1'b0;
  endtask

  // One SPI bit: MOSI set up, MISO checked before the leading edge, then
  // leading and trailing edges 8 Clk apart.
  task automatic spi_bit(input logic b, input logic e);
    mosi = b;
    repeat (5) tick();
    exp_miso = e;
    miso_chk = 1'b1;
    repeat (3) tick();
    miso_chk = 1'b0;
    rx_bit = miso0;
    sclk = 1'b1;
    last_evt = cyc;
    repeat (8) tick();
    sclk = 1'b0;
    last_evt = cyc;
  endtask

  task automatic hook_pre(input int kind);
    if (kind == 2) m_new[coll_addr] = 1'b0;
  endtask

  // ARM access landing in the same Clk as the DUT acts on the trailing edge
  // that just happened (two synchroniser stages, then the state update).
  task automatic hook_post(input int kind);
    if (kind == 1) m_miso[coll_addr] = coll_data;
    if (kind != 0) begin
      tick();
      tick();
      addr = coll_addr;
      if (kind == 1) begin
        we = 1'b1;
        wdata = coll_data;
      end else begin
        re = 1'b1;
      end
      last_evt = cyc;
      tick();
      we = 1'b0;
      re = 1'b0;
      last_evt = cyc;
    end
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input int ncmd, input int nwords,
                           input int extra, input int hook_unit, input int hook_kind);
    logic [3:0]  a;
    logic [31:0] cur;
    logic [31:0] rxw;
    int          err_exp;
    err_exp = 0;
    cs = 1'b0;
    m_busy = 1'b1;
    last_evt = cyc;
    repeat (6) tick();
    for (int i = 0; i < ncmd; i++) spi_bit(cmd[7-i], 1'b0);
    if (ncmd == 8) begin
      a = cmd[3:0];
      if (hook_unit == 0) hook_pre(hook_kind);
      cur = m_miso[a];
      if (hook_unit == 0) hook_post(hook_kind);
      for (int k = 0; k < nwords; k++) begin
        rxw = '0;
        for (int i = 31; i >= 0; i--) begin
          spi_bit(tx_words[k][i], cur[i]);
          rxw = {rxw[30:0], rx_bit};
        end
        rx_words[k] = rxw;
        if (hook_unit == k + 1) hook_pre(hook_kind);
        if (cmd[7]) begin
          m_mosi[a] = tx_words[k];
          m_new[a] = 1'b1;
        end
        if (cmd[6]) a = a + 4'd1;
        cur = m_miso[a];
        if (hook_unit == k + 1) hook_post(hook_kind);
      end
      for (int i = 31; i > 31 - extra; i--) spi_bit(1'($urandom_range(0, 1)), cur[i]);
      if (extra > 0) err_exp = 1;
    end else if (ncmd > 0) begin
      err_exp = 1;
    end
    repeat (4) tick();
    cs = 1'b1;
    m_busy = 1'b0;
    exp_err_total += err_exp;
    last_evt = cyc;
    repeat (10) tick();
  endtask

  task automatic arm_write(input logic [3:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    we = 1'b1;
    last_evt = cyc;
    tick();
    we = 1'b0;
    m_miso[a] = d;
    repeat (7) tick();
  endtask

  task automatic arm_ack(input logic [3:0] a);
    addr = a;
    re = 1'b1;
    last_evt = cyc;
    tick();
    re = 1'b0;
    m_new[a] = 1'b0;
    last_evt = cyc;
    repeat (7) tick();
  endtask

  task automatic set_addr(input logic [3:0] a);
    addr = a;
    last_evt = cyc;
    repeat (8) tick();
  endtask

  initial begin
    logic [7:0] cmd;
    int kind, nw;
    Reset_n = 1'b0;
    sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    coll_addr = '0; coll_data = '0;
    model_reset();
    repeat (5) tick();
    Reset_n = 1'b1;
    last_evt = cyc;
    repeat (8) tick();
    check("por_busy", busy0, 1'b0);
    check("por_new", new0, 16'h0000);
    check("por_miso", miso0, 1'b0);
    check("por_read", rd0, 32'h0);

    // Put state into the banks, then reset in the middle of a frame.
    arm_write(4'd2, 32'h0BAD_F00D);
    tx_words[0] = 32'h5555_AAAA;
    spi_frame(8'h89, 8, 1, 0, -1, 0);
    cs = 1'b0; m_busy = 1'b1; last_evt = cyc;
    repeat (6) tick();
    spi_bit(1'b1, 1'b0);
    spi_bit(1'b0, 1'b0);
    spi_bit(1'b1, 1'b0);
    Reset_n = 1'b0;
    model_reset();
    last_evt = cyc;
    repeat (3) tick();
    cs = 1'b1;
    repeat (3) tick();
    Reset_n = 1'b1;
    last_evt = cyc;
    repeat (10) tick();
    check("rst_busy", busy1, 1'b0);
    check("rst_new", new1, 16'h0000);
    check("rst_miso", miso1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      set_addr(4'(i));
      check("rst_read", rd0, 32'h0);
    end

    // Single write, then acknowledge.
    tx_words[0] = 32'hDEAD_BEEF;
    spi_frame(8'h83, 8, 1, 0, -1, 0);
    set_addr(4'd3);
    check("wr_read", rd0, 32'hDEAD_BEEF);
    check("wr_new", new0, 16'h0008);
    check("wr_new_cpol1", new1, 16'h0008);
    arm_ack(4'd3);
    check("ack_new", new0, 16'h0000);

    // Single read.
    arm_write(4'd5, 32'hA5A5_0F0F);
    tx_words[0] = $urandom;
    spi_frame(8'h05, 8, 1, 0, -1, 0);
    check("rd_word", rx_words[0], 32'hA5A5_0F0F);
    check("rd_new", new0, 16'h0000);

    // Burst with wrap.
    arm_write(4'd14, $urandom);
    arm_write(4'd15, $urandom);
    arm_write(4'd0, $urandom);
    tx_words[0] = 32'h1111_1111;
    tx_words[1] = 32'h2222_2222;
    tx_words[2] = 32'h3333_3333;
    spi_frame(8'hCE, 8, 3, 0, -1, 0);
    check("burst_new", new0, 16'hC001);
    set_addr(4'd15);
    check("burst_rd15", rd0, 32'h2222_2222);
    set_addr(4'd0);
    check("burst_rd0", rd0, 32'h3333_3333);

    // Framing errors: partial word, then partial command.
    tx_words[0] = $urandom;
    spi_frame(8'h82, 8, 0, 13, -1, 0);
    spi_frame(8'h82, 5, 0, 0, -1, 0);
    check("ferr_count", err_seen0, 2);
    check("ferr_new2", new0[2], 1'b0);
    set_addr(4'd2);
    check("ferr_rd2", rd0, 32'h0);

    // Collision: ARM write to miso[7] in the shifter-load Clk.
    arm_write(4'd7, 32'h1234_5678);
    coll_addr = 4'd7;
    coll_data = 32'hCAFE_F00D;
    tx_words[0] = $urandom;
    spi_frame(8'h07, 8, 1, 0, 0, 1);
    check("coll_old", rx_words[0], 32'h1234_5678);
    spi_frame(8'h07, 8, 1, 0, -1, 0);
    check("coll_new", rx_words[0], 32'hCAFE_F00D);

    // Collision: New[4] set and cleared in the same Clk.
    coll_addr = 4'd4;
    tx_words[0] = 32'h0000_0044;
    spi_frame(8'h84, 8, 1, 0, 1, 2);
    check("setwins0", new0[4], 1'b1);
    check("setwins1", new1[4], 1'b1);

    // Randomized frames.
    for (int f = 0; f < 12; f++) begin
      repeat ($urandom_range(0, 3)) arm_write(4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 1) == 1) arm_ack(4'($urandom_range(0, 15)));
      cmd = 8'($urandom);
      nw = $urandom_range(0, 2);
      for (int k = 0; k < 4; k++) tx_words[k] = $urandom;
      kind = $urandom_range(0, 4);
      if (kind == 0) spi_frame(cmd, $urandom_range(1, 7), 0, 0, -1, 0);
      else if (kind == 1) spi_frame(cmd, 8, nw, $urandom_range(1, 31), -1, 0);
      else spi_frame(cmd, 8, nw, 0, -1, 0);
      set_addr(4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
